// File: rtl/myaclint_pkg.sv
// Shared register map, region-select encoding and decode helpers for the ACLINT block.
package myaclint_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned OFF_W  = 16;

  localparam logic [OFF_W-1:0] MSIP_BASE     = 16'h0000;
  localparam logic [OFF_W-1:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [OFF_W-1:0] MTIME_BASE    = 16'hBFF8;
  localparam logic [OFF_W-1:0] SETSSIP_BASE  = 16'hC000;

  typedef enum logic [2:0] {
    RGN_NONE     = 3'd0,
    RGN_MSIP     = 3'd1,
    RGN_MTIMECMP = 3'd2,
    RGN_MTIME    = 3'd3,
    RGN_SETSSIP  = 3'd4
  } region_e;

  typedef struct packed {
    region_e          region;
    logic [OFF_W-1:0] index;
    logic             hi;
  } decode_t;

  // Index is left unbounded; callers match it against their own hart range.
  function automatic decode_t decode(input logic [OFF_W-1:0] off);
    decode_t d;
    d.region = RGN_NONE;
    d.index  = '0;
    d.hi     = 1'b0;
    if (off >= SETSSIP_BASE) begin
      d.region = RGN_SETSSIP;
      d.index  = (off - SETSSIP_BASE) >> 2;
    end else if (off >= MTIME_BASE) begin
      d.region = RGN_MTIME;
      d.hi     = off[2];
    end else if (off >= MTIMECMP_BASE) begin
      d.region = RGN_MTIMECMP;
      d.index  = (off - MTIMECMP_BASE) >> 3;
      d.hi     = off[2];
    end else begin
      d.region = RGN_MSIP;
      d.index  = (off - MSIP_BASE) >> 2;
    end
    return d;
  endfunction

  function automatic logic [WORD_W-1:0] merge_bytes(input logic [WORD_W-1:0] old,
                                                    input logic [WORD_W-1:0] data,
                                                    input logic [WORD_W/8-1:0] strb);
    logic [WORD_W-1:0] res;
    res = old;
    for (int i = 0; i < int'(WORD_W / 8); i++) begin
      if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/myaclint_tick.sv
// mtime tick source: synchronised rt_clk rising edge or a free-running clk prescaler.
module myaclint_tick
  import myaclint_pkg::*;
#(
  parameter int unsigned TICK_MODE = 0,
  parameter int unsigned PRESCALE  = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic rt_clk,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [2:0]    sync;
  logic [CW-1:0] cnt;

  // Registered tick fires when cnt is PRESCALE-2 so it lands once per PRESCALE cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      sync <= {sync[1:0], rt_clk};
      cnt  <= (cnt == CW'(PRESCALE - 1)) ? '0 : cnt + CW'(1);
      tick <= (TICK_MODE == 1) ? (cnt == CW'(PRESCALE - 2)) : (sync[1] & ~sync[2]);
    end
  end

endmodule

// File: rtl/myaclint.sv
// Core-local interruptor: MSIP, SETSSIP, MTIMECMP and MTIME behind a request/ready-pulse bus.
module myaclint
  import myaclint_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned N_HARTS   = 1,
  parameter int unsigned TICK_MODE = 0,
  parameter int unsigned PRESCALE  = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rt_clk,
  input  logic                  valid,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
  output logic [N_HARTS-1:0]    mtip,
  output logic [N_HARTS-1:0]    msip,
  output logic [N_HARTS-1:0]    ssip_set
);

  logic              tick;
  logic              accept;
  logic              is_write;
  logic              lo_read;
  logic              mtime_wr;
  logic [63:0]       mtime_wval;
  logic [DATA_W-1:0] rd_val;
  decode_t           dec;

  logic [63:0]       mtime;
  logic [63:0]       mtimecmp [N_HARTS];
  logic [31:0]       shadow;
  logic              last_lo_read;
  logic              unused_addr;

  assign unused_addr = ^address[ADDR_W-1:OFF_W];

  myaclint_tick #(
    .TICK_MODE (TICK_MODE),
    .PRESCALE  (PRESCALE)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .rt_clk (rt_clk),
    .tick   (tick)
  );

  // Decode and read mux; indices at or above N_HARTS match no hart and read as zero.
  always_comb begin
    accept     = valid & ~ready;
    is_write   = |wstrb;
    dec        = decode(address[OFF_W-1:0]);
    lo_read    = (dec.region == RGN_MTIME) && !dec.hi && !is_write;
    mtime_wr   = accept && is_write && (dec.region == RGN_MTIME);
    mtime_wval = dec.hi ? {merge_bytes(mtime[63:32], wdata, wstrb), mtime[31:0]}
                        : {mtime[63:32], merge_bytes(mtime[31:0], wdata, wstrb)};
    rd_val     = '0;
    case (dec.region)
      RGN_MSIP: begin
        for (int unsigned h = 0; h < N_HARTS; h++) begin
          if (dec.index == 16'(h)) rd_val = DATA_W'(msip[h]);
        end
      end
      RGN_MTIMECMP: begin
        for (int unsigned h = 0; h < N_HARTS; h++) begin
          if (dec.index == 16'(h)) rd_val = dec.hi ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
        end
      end
      RGN_MTIME: rd_val = dec.hi ? (last_lo_read ? shadow : mtime[63:32]) : mtime[31:0];
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mtime        <= '0;
      shadow       <= '0;
      last_lo_read <= 1'b0;
      msip         <= '0;
      mtip         <= '0;
      ssip_set     <= '0;
      ready        <= 1'b0;
      rdata        <= '0;
      for (int unsigned h = 0; h < N_HARTS; h++) mtimecmp[h] <= '1;
    end else begin
      ready    <= accept;
      ssip_set <= '0;
      for (int unsigned h = 0; h < N_HARTS; h++) mtip[h] <= (mtime >= mtimecmp[h]);
      // A bus write to either mtime word suppresses the tick in that cycle.
      if (mtime_wr)  mtime <= mtime_wval;
      else if (tick) mtime <= mtime + 64'd1;
      if (accept) begin
        rdata        <= rd_val;
        last_lo_read <= lo_read;
        if (lo_read) shadow <= mtime[63:32];
        for (int unsigned h = 0; h < N_HARTS; h++) begin
          if (is_write && (dec.index == 16'(h))) begin
            case (dec.region)
              RGN_MSIP:    if (wstrb[0]) msip[h] <= wdata[0];
              RGN_SETSSIP: if (wstrb[0] && wdata[0]) ssip_set[h] <= 1'b1;
              RGN_MTIMECMP: begin
                if (dec.hi) mtimecmp[h][63:32] <= merge_bytes(mtimecmp[h][63:32], wdata, wstrb);
                else        mtimecmp[h][31:0]  <= merge_bytes(mtimecmp[h][31:0], wdata, wstrb);
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_myaclint.sv
// Directed bench for myaclint: 4 harts, prescaled tick of 4, read scoreboard plus mtime reference.
module tb_myaclint;

  localparam int unsigned NH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          rt_clk;
  logic          valid;
  logic [31:0]   address;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic [31:0]   rdata;
  logic          ready;
  logic [NH-1:0] mtip;
  logic [NH-1:0] msip;
  logic [NH-1:0] ssip_set;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [31:0]   exp_q[$];
  logic [NH-1:0] mtip_r;
  logic [NH-1:0] ssip_r;

  // Reference mtime: +1 on every 4th edge after reset, bus writes take priority.
  int            ecnt    = 0;
  logic [63:0]   m_mtime = '0;
  logic          m_wr_lo = 1'b0;
  logic          m_wr_hi = 1'b0;
  logic [31:0]   m_wval  = '0;

  myaclint #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .N_HARTS   (NH),
    .TICK_MODE (1),
    .PRESCALE  (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rt_clk   (rt_clk),
    .valid    (valid),
    .address  (address),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .rdata    (rdata),
    .ready    (ready),
    .mtip     (mtip),
    .msip     (msip),
    .ssip_set (ssip_set)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      ecnt    <= 0;
      m_mtime <= '0;
    end else begin
      ecnt <= ecnt + 1;
      if (m_wr_lo)                  m_mtime <= {m_mtime[63:32], m_wval};
      else if (m_wr_hi)             m_mtime <= {m_wval, m_mtime[31:0]};
      else if ((ecnt + 1) % 4 == 0) m_mtime <= m_mtime + 64'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with ready low; returns at the negedge after the ready pulse.
  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] exp, input string tag);
    valid   = 1'b1;
    address = a;
    wdata   = d;
    wstrb   = s;
    m_wval  = d;
    m_wr_lo = (s != 4'h0) && (a[15:0] == 16'hBFF8);
    m_wr_hi = (s != 4'h0) && (a[15:0] == 16'hBFFC);
    if (s == 4'h0) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    valid   = 1'b0;
    wstrb   = 4'h0;
    m_wr_lo = 1'b0;
    m_wr_hi = 1'b0;
    @(negedge clk);
    mtip_r = mtip;
    ssip_r = ssip_set;
    check({tag, "/ready"}, 32'(ready), 32'd1);
    if (s == 4'h0 && exp_q.size() > 0) check({tag, "/rdata"}, rdata, exp_q.pop_front());
    @(negedge clk);
    check({tag, "/ready_drop"}, 32'(ready), 32'd0);
  endtask

  initial begin
    reset = 1'b1; rt_clk = 1'b0; valid = 1'b0;
    address = '0; wdata = '0; wstrb = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mtip", 32'(mtip), 32'd0);
    check("rst_msip", 32'(msip), 32'd0);
    check("rst_ssip", 32'(ssip_set), 32'd0);

    // Reset value of mtimecmp[0]
    bus(32'h4000, 32'h0, 4'h0, 32'hFFFF_FFFF, "cmp0_lo");
    bus(32'h4004, 32'h0, 4'h0, 32'hFFFF_FFFF, "cmp0_hi");
    check("cmp_rst_mtip", 32'(mtip), 32'd0);

    // mtimecmp[0] = 0x10, mtip asserts one cycle after mtime reaches it at edge 64
    bus(32'h4004, 32'h0, 4'hF, 32'h0, "wr_cmp0_hi");
    bus(32'h4000, 32'h10, 4'hF, 32'h0, "wr_cmp0_lo");
    bus(32'hBFF8, 32'h0, 4'h0, m_mtime[31:0], "mtime_early");
    while (ecnt < 64) @(negedge clk);
    check("mtip_at_64", 32'(mtip), 32'd0);
    @(negedge clk);
    check("mtip_at_65", 32'(mtip), 32'b0001);
    bus(32'h4004, 32'h1, 4'hF, 32'h0, "wr_cmp0_hi1");
    check("mtip_in_ready", 32'(mtip_r), 32'b0001);
    check("mtip_cleared", 32'(mtip), 32'd0);

    // Wrap of mtime from all-ones to zero
    bus(32'hBFFC, 32'hFFFF_FFFF, 4'hF, 32'h0, "wr_mt_hi");
    while ((ecnt + 1) % 4 != 1) @(negedge clk);
    bus(32'hBFF8, 32'hFFFF_FFFF, 4'hF, 32'h0, "wr_mt_lo");
    bus(32'hBFF8, 32'h0, 4'h0, 32'hFFFF_FFFF, "mt_lo_pre");
    bus(32'hBFF8, 32'h0, 4'h0, 32'h0, "mt_lo_wrap");
    bus(32'hBFFC, 32'h0, 4'h0, 32'h0, "mt_hi_wrap");

    // Write to mtime low on a tick edge keeps the written value
    while ((ecnt + 1) % 4 != 0) @(negedge clk);
    bus(32'hBFF8, 32'h1234_5678, 4'hF, 32'h0, "wr_mt_on_tick");
    bus(32'hBFF8, 32'h0, 4'h0, 32'h1234_5678, "mt_after_tick_wr");

    // Shadowed high read across a carry, then a live high read
    bus(32'hBFFC, 32'h0, 4'hF, 32'h0, "wr_mt_hi0");
    while ((ecnt + 1) % 4 != 1) @(negedge clk);
    bus(32'hBFF8, 32'hFFFF_FFFF, 4'hF, 32'h0, "wr_mt_lo_ff");
    bus(32'hBFF8, 32'h0, 4'h0, 32'hFFFF_FFFF, "shadow_lo");
    bus(32'hBFFC, 32'h0, 4'h0, 32'h0, "shadow_hi");
    bus(32'hBFFC, 32'h0, 4'h0, 32'h1, "live_hi");
    check("model_mtime_hi", 32'(m_mtime[63:32]), 32'h1);

    // Software interrupts and out-of-range harts
    bus(32'h0008, 32'h1, 4'hF, 32'h0, "wr_msip2");
    check("msip2", 32'(msip), 32'b0100);
    bus(32'hC00C, 32'h1, 4'hF, 32'h0, "wr_ssip3");
    check("ssip3_pulse", 32'(ssip_r), 32'b1000);
    check("ssip3_clear", 32'(ssip_set), 32'd0);
    bus(32'h0010, 32'h1, 4'hF, 32'h0, "wr_msip4");
    check("msip4_ignored", 32'(msip), 32'b0100);
    bus(32'h0010, 32'h0, 4'h0, 32'h0, "rd_msip4");
    bus(32'h0008, 32'h0, 4'h0, 32'h1, "rd_msip2");
    bus(32'hC00C, 32'h0, 4'h0, 32'h0, "rd_ssip3");
    bus(32'h4020, 32'h0, 4'h0, 32'h0, "rd_cmp4");

    // Byte-strobed write into mtimecmp[0] low
    bus(32'h4000, 32'hFFFF_FFFF, 4'hF, 32'h0, "wr_cmp0_ff");
    bus(32'h4000, 32'h0000_AB00, 4'b0010, 32'h0, "wr_cmp0_b1");
    bus(32'h4000, 32'h0, 4'h0, 32'hFFFF_ABFF, "rd_cmp0_b1");

    // Held valid: a request is accepted only every second cycle
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'hFFFF_FFFF);
    valid = 1'b1; address = 32'h4008; wstrb = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("b2b_ready%0d", i), 32'(ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (ready === 1'b1 && exp_q.size() > 0) check($sformatf("b2b_rdata%0d", i), rdata, exp_q.pop_front());
    end
    valid = 1'b0;
    @(negedge clk);

    // Request coinciding with reset is dropped and state returns to reset values
    valid = 1'b1; address = 32'h0; wdata = 32'h1; wstrb = 4'hF; reset = 1'b1;
    @(negedge clk);
    check("abort_ready", 32'(ready), 32'd0);
    valid = 1'b0; wstrb = 4'h0; reset = 1'b0;
    check("abort_msip", 32'(msip), 32'd0);
    check("abort_mtip", 32'(mtip), 32'd0);
    check("abort_rdata", rdata, 32'd0);
    bus(32'hBFF8, 32'h0, 4'h0, 32'h0, "post_rst_mt_lo");
    bus(32'h4004, 32'h0, 4'h0, 32'hFFFF_FFFF, "post_rst_cmp_hi");
    bus(32'h0000, 32'h0, 4'h0, 32'h0, "post_rst_msip0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/myaclint.md
MYACLINT -- requirements
Module: myaclint

Interface
REQ-001 SHALL have parameters: ADDR_W, 32, bus address width; DATA_W, 32, bus data width (only 32 supported); N_HARTS, 1, hart count (1..32); TICK_MODE, 0, 0 = rt_clk edge, 1 = clk prescaler; PRESCALE, 100, clk cycles per tick when TICK_MODE = 1 (>= 2).
REQ-002 SHALL have ports: clk in 1 system clock; reset in 1 synchronous active-high reset; rt_clk in 1 asynchronous real-time clock; valid in 1 request valid; address in ADDR_W request address; wdata in DATA_W write data; wstrb in DATA_W/8 byte strobes (0 = read); rdata out DATA_W response data; ready out 1 response pulse; mtip out N_HARTS timer interrupt; msip out N_HARTS machine software interrupt; ssip_set out N_HARTS supervisor software interrupt set pulse.
REQ-003 SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 SHALL decode address[15:0]: MSIP 0x0000+4*h; MTIMECMP 0x4000+8*h (low word +0, high word +4); MTIME 0xBFF8 low, 0xBFFC high; SETSSIP 0xC000+4*h.
REQ-005 SHALL accept a request on any clk edge with valid=1 and ready=0; ready SHALL pulse high for exactly one cycle, one cycle after acceptance, with rdata valid in that cycle.
REQ-006 SHALL ignore valid while ready=1 (back-to-back requests accepted every second cycle).
REQ-007 SHALL write only bytes whose wstrb bit is set; wstrb=0 is a read.
REQ-008 SHALL, for unmapped addresses and hart indices >= N_HARTS, ignore writes, return rdata=0, and still pulse ready.
REQ-009 SHALL implement msip[h] as bit 0 of MSIP word h; bits 31:1 read 0; write of byte 0 updates bit.
REQ-010 SHALL, on a write to SETSSIP h with byte 0 strobed and wdata[0]=1, pulse ssip_set[h] for one cycle, same cycle as ready; SETSSIP reads return 0.
REQ-011 SHALL increment 64-bit mtime by 1 per tick, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-012 SHALL, when TICK_MODE=0, generate a tick on each rising rt_clk edge after a 2-flop synchroniser plus edge detector (3-cycle latency).
REQ-013 SHALL, when TICK_MODE=1, generate one tick every PRESCALE clk cycles from a counter counting 0..PRESCALE-1.
REQ-014 SHALL give a bus write to mtime priority over a tick in the same cycle (written value retained, no increment).
REQ-015 SHALL, on a read of mtime low word, latch mtime[63:32] into a shadow register; a read of mtime high word SHALL return the shadow if the immediately preceding accepted request was an mtime low read, else live mtime[63:32].
REQ-016 SHALL register mtip[h] = (mtime >= mtimecmp[h]), unsigned 64-bit, updated every clk with one cycle latency.
REQ-017 SHALL keep mtip level-sensitive: it clears one cycle after mtimecmp is written above mtime.

Reset
REQ-018 SHALL on reset set: mtime=0; every mtimecmp=0xFFFF_FFFF_FFFF_FFFF; msip=0; mtip=0; ssip_set=0; ready=0; rdata=0; shadow=0; prescaler and synchroniser state=0.
REQ-019 SHALL abort any accepted request on reset: no ready pulse follows it.

Structure
REQ-020 SHALL place region base offsets (MSIP, MTIMECMP, MTIME, SETSSIP) and the region-select encoding in a shared package.
REQ-021 SHALL implement tick generation (synchroniser, edge detect, prescaler, TICK_MODE select) in sub-module myaclint_tick with single output tick.

Verification
REQ-022 Reset, then read 0x4000 and 0x4004 -> rdata 0xFFFFFFFF both, ready one cycle after each acceptance, mtip=0.
REQ-023 TICK_MODE=1, PRESCALE=4, write mtimecmp[0]=0x10 -> mtime reaches 0x10 after 64 cycles, mtip[0]=1 one cycle later; write 0x4004=0x1 -> mtip[0]=0 next cycle.
REQ-024 Write mtime=0xFFFF_FFFF_FFFF_FFFF, one tick -> mtime reads 0; write mtime low coinciding with a tick -> written value read back exactly.
REQ-025 N_HARTS=4: write 0x0008=1 -> msip=4'b0100; write 0xC00C=1 -> ssip_set=4'b1000 for one cycle; write 0x0010=1 (hart 4) -> ignored, ready pulses, read returns 0.
REQ-026 mtime=0x0000_0000_FFFF_FFFF, read low, tick occurs, read high -> 0x00000000 (shadow); standalone high read -> 0x00000001.
REQ-027 Write 0x4000 with wstrb=4'b0010, wdata=0x0000AB00 -> mtimecmp[0][31:0]=0xFFFFABFF.
